// File: rtl/instruction_serializer_pkg.sv
// Shared definitions for the instruction link transmitter: word layout and FSM states.
package instruction_serializer_pkg;

  localparam int INSTR_W       = 11;
  localparam int ACTIVE_BIT    = 10;
  localparam int MODE_BIT      = 9;
  localparam int SERVO_SEL_BIT = 8;
  localparam int POS_MSB       = 7;
  localparam int BIT_IDX_W     = $clog2(INSTR_W);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LRST   = 3'd1,
    ST_SETUP  = 3'd2,
    ST_STROBE = 3'd3,
    ST_HOLD   = 3'd4,
    ST_GAP    = 3'd5
  } ser_state_e;

  function automatic int max_of5(input int a, input int b, input int c, input int d, input int e);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    if (e > m) m = e;
    return m;
  endfunction

endpackage

// File: rtl/instruction_serializer_if.sv
// Word handshake between a command source and the serializer.
interface instruction_serializer_if;
  import instruction_serializer_pkg::*;

  logic               tx_valid;
  logic [INSTR_W-1:0] tx_data;
  logic               tx_ready;
  logic               busy;

  modport master (output tx_valid, output tx_data, input tx_ready, input busy);
  modport slave  (input tx_valid, input tx_data, output tx_ready, output busy);
endinterface

// File: rtl/instruction_serializer_phase_timer.sv
// Loadable down-counter timing each serializer phase; expired flags a count of zero.
module phase_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expired
);

  logic [W-1:0] count;

  // Count down from the loaded value and park at zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/instruction_serializer.sv
// Serializes an 11-bit instruction MSB first over a link_reset / set_bit / input_bit link.
module instruction_serializer
  import instruction_serializer_pkg::*;
#(
  parameter int RST_CYCLES  = 100,
  parameter int BIT_SETUP   = 50,
  parameter int STROBE_HIGH = 100,
  parameter int BIT_HOLD    = 50,
  parameter int FRAME_GAP   = 1000
) (
  input  logic                     clk,
  input  logic                     reset,
  instruction_serializer_if.slave  tx,
  output logic                     link_reset,
  output logic                     set_bit,
  output logic                     input_bit,
  output logic                     frame_done
);

  localparam int CNT_W = $clog2(max_of5(RST_CYCLES, BIT_SETUP, STROBE_HIGH, BIT_HOLD, FRAME_GAP)) + 1;

  // Each phase loads (length-1) on entry and leaves when the timer reads zero.
  localparam logic [CNT_W-1:0] LD_RST   = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'(BIT_SETUP - 1);
  localparam logic [CNT_W-1:0] LD_HIGH  = CNT_W'(STROBE_HIGH - 1);
  localparam logic [CNT_W-1:0] LD_HOLD  = CNT_W'(BIT_HOLD - 1);
  localparam logic [CNT_W-1:0] LD_GAP   = CNT_W'(FRAME_GAP - 1);

  ser_state_e           state, state_nxt;
  logic [INSTR_W-1:0]   shreg, shreg_nxt;
  logic [BIT_IDX_W-1:0] bit_idx, bit_idx_nxt;
  logic                 ready, ready_nxt;
  logic                 busy, busy_nxt;
  logic                 link_reset_nxt, set_bit_nxt, input_bit_nxt, frame_done_nxt;
  logic                 load;
  logic [CNT_W-1:0]     load_val;
  logic                 expired;

  phase_timer #(.W(CNT_W)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .load_val (load_val),
    .expired  (expired)
  );

  assign tx.tx_ready = ready;
  assign tx.busy     = busy;

  // State, shift register and all link outputs are registered together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      shreg      <= '0;
      bit_idx    <= '0;
      ready      <= 1'b1;
      busy       <= 1'b0;
      link_reset <= 1'b0;
      set_bit    <= 1'b0;
      input_bit  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      shreg      <= shreg_nxt;
      bit_idx    <= bit_idx_nxt;
      ready      <= ready_nxt;
      busy       <= busy_nxt;
      link_reset <= link_reset_nxt;
      set_bit    <= set_bit_nxt;
      input_bit  <= input_bit_nxt;
      frame_done <= frame_done_nxt;
    end
  end

  // Phase sequencing and next values of the registered outputs.
  always_comb begin
    state_nxt      = state;
    shreg_nxt      = shreg;
    bit_idx_nxt    = bit_idx;
    ready_nxt      = ready;
    busy_nxt       = busy;
    link_reset_nxt = link_reset;
    set_bit_nxt    = set_bit;
    input_bit_nxt  = input_bit;
    frame_done_nxt = 1'b0;
    load           = 1'b0;
    load_val       = '0;
    case (state)
      ST_IDLE: begin
        if (tx.tx_valid) begin
          state_nxt      = ST_LRST;
          shreg_nxt      = tx.tx_data;
          bit_idx_nxt    = BIT_IDX_W'(INSTR_W - 1);
          ready_nxt      = 1'b0;
          busy_nxt       = 1'b1;
          link_reset_nxt = 1'b1;
          set_bit_nxt    = 1'b0;
          input_bit_nxt  = 1'b0;
          load           = 1'b1;
          load_val       = LD_RST;
        end
      end
      ST_LRST: begin
        if (expired) begin
          state_nxt      = ST_SETUP;
          link_reset_nxt = 1'b0;
          input_bit_nxt  = shreg[bit_idx];
          load           = 1'b1;
          load_val       = LD_SETUP;
        end
      end
      ST_SETUP: begin
        if (expired) begin
          state_nxt   = ST_STROBE;
          set_bit_nxt = 1'b1;
          load        = 1'b1;
          load_val    = LD_HIGH;
        end
      end
      ST_STROBE: begin
        if (expired) begin
          state_nxt      = ST_HOLD;
          set_bit_nxt    = 1'b0;
          frame_done_nxt = (bit_idx == '0);
          load           = 1'b1;
          load_val       = LD_HOLD;
        end
      end
      ST_HOLD: begin
        if (expired) begin
          load = 1'b1;
          if (bit_idx != '0) begin
            state_nxt     = ST_SETUP;
            bit_idx_nxt   = bit_idx - BIT_IDX_W'(1);
            input_bit_nxt = shreg[bit_idx - BIT_IDX_W'(1)];
            load_val      = LD_SETUP;
          end else begin
            state_nxt = ST_GAP;
            load_val  = LD_GAP;
          end
        end
      end
      ST_GAP: begin
        if (expired) begin
          state_nxt = ST_IDLE;
          ready_nxt = 1'b1;
          busy_nxt  = 1'b0;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        ready_nxt = 1'b1;
        busy_nxt  = 1'b0;
      end
    endcase
  end

endmodule
